alu_seq: RTL

Parametrised, clocked successor to the team's combinational 2-bit ALU. It registers its result and raises status flags. It accepts one operation per cycle through a valid/ready handshake and holds results under output back-pressure. It adds XOR, shift, a multi-cycle unsigned multiply and an internal accumulator. It sits between an operand source and a result consumer in the datapath.

---
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with valid/ready handshakes on both sides.
//
// Accepts one operation per cycle (A, B, sel sampled on in_valid && in_ready), registers the
// result and its flags, and holds them until the consumer takes them (out_valid && out_ready).
// MUL is a WIDTH-cycle shift-add; ACC adds A into a private 2*WIDTH accumulator.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   A, B      in   WIDTH-bit unsigned operands
//   sel       in   opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 ACC
//   in_valid  in   operands/opcode valid
//   in_ready  out  operation can be accepted this cycle
//   result    out  2*WIDTH-bit registered result, zero-extended
//   zero      out  result == 0
//   carry     out  ADD carry-out / SUB borrow / ACC wrap, 0 otherwise
//   out_valid out  result and flags valid
//   out_ready in   consumer takes the result

module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic [2:0]             sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [2*WIDTH-1:0]     result,
    output logic                   zero,
    output logic                   carry,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned W2   = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;
    localparam logic [2:0] OpAcc = 3'b111;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("alu_seq: WIDTH must be >= 2 and a power of two");
    end

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [W2-1:0]     result_q, result_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [W2-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [W2-1:0]     prod_q, prod_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              accept;
    logic [WIDTH:0]    sum_w;
    logic [WIDTH:0]    diff_w;
    logic [W2:0]       acc_sum;
    logic [W2-1:0]     shl_w;
    logic [W2-1:0]     pp_add;
    logic [W2-1:0]     op_res;
    logic              op_carry;

    assign in_ready  = (state_q == StIdle) || ((state_q == StHold) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StHold);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;

    // Operand arithmetic for the single-cycle ops.
    assign sum_w   = {1'b0, A} + {1'b0, B};
    // The top bit of the extended difference is the borrow, i.e. A < B.
    assign diff_w  = {1'b0, A} - {1'b0, B};
    assign acc_sum = {1'b0, acc_q} + {{(WIDTH + 1){1'b0}}, A};
    // A shift amount >= W2 pushes every bit out, giving 0.
    assign shl_w   = {{WIDTH{1'b0}}, A} << B;

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign pp_add  = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        unique case (sel)
            OpAdd: begin
                op_res   = {{(WIDTH - 1){1'b0}}, sum_w};
                op_carry = sum_w[WIDTH];
            end
            OpSub: begin
                op_res   = {{(WIDTH - 1){1'b0}}, diff_w};
                op_carry = diff_w[WIDTH];
            end
            OpAnd: op_res = {{WIDTH{1'b0}}, A & B};
            OpOr:  op_res = {{WIDTH{1'b0}}, A | B};
            OpXor: op_res = {{WIDTH{1'b0}}, A ^ B};
            OpShl: op_res = shl_w;
            OpAcc: begin
                op_res   = acc_sum[W2-1:0];
                op_carry = acc_sum[W2];
            end
            OpMul: op_res = '0;
            default: op_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle, StHold: begin
                if (accept) begin
                    if (sel == OpMul) begin
                        state_d  = StBusy;
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end else begin
                        state_d  = StHold;
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        carry_d  = op_carry;
                        if (sel == OpAcc) begin
                            acc_d = acc_sum[W2-1:0];
                        end
                    end
                end else if ((state_q == StHold) && out_ready) begin
                    state_d = StIdle;
                end
                // HOLD without out_ready falls through: result and flags stay frozen.
            end
            StBusy: begin
                prod_d   = pp_add;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d  = StHold;
                    result_d = pp_add;
                    zero_d   = (pp_add == '0);
                    carry_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
